pong_text_overlay_ctrl: RTL and testbench



---
 rtl/pong_text_overlay_ctrl.sv | 170 +++++++++++++++++
 tb/tb_pong_text_overlay_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pong_text_overlay_ctrl.sv
// PONG message overlay: game-message FSM with blink/hold timing, plus a four-stage
// pipeline from pixel coordinates through the message and font ROMs to text_on.
module pong_text_overlay_ctrl #(
    parameter int TEXT_X0      = 192,
    parameter int TEXT_Y0      = 208,
    parameter int SCALE_LOG2   = 1,
    parameter int BLINK_FRAMES = 30,
    parameter int OVER_FRAMES  = 180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        frame_tick,
    input  logic        game_start,
    input  logic        game_over,
    output logic [7:0]  char_xy,
    input  logic [6:0]  start_code,
    input  logic [6:0]  over_code,
    output logic [10:0] font_addr,
    input  logic [7:0]  font_word,
    output logic        text_on,
    output logic        play_active
);
    localparam int BOX_W = 128 << SCALE_LOG2;
    localparam int BOX_H = 16 << SCALE_LOG2;
    localparam int BW    = $clog2(BLINK_FRAMES);
    localparam int OW    = $clog2(OVER_FRAMES);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
    localparam logic [OW-1:0] OVER_LAST  = OW'(OVER_FRAMES - 1);

    typedef enum logic [1:0] {ST_START = 2'd0, ST_PLAY = 2'd1, ST_OVER = 2'd2} state_t;
    typedef enum logic [1:0] {DISP_START = 2'd0, DISP_NONE = 2'd1, DISP_OVER = 2'd2} disp_t;

    state_t          state_q, state_d;
    disp_t           disp_sel_q, disp_sel_d;
    logic            disp_vis_q, disp_vis_d;
    logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
    logic            blink_vis_q, blink_vis_d;
    logic [OW-1:0]   over_cnt_q, over_cnt_d;
    logic            play_active_q, play_active_d;

    logic [7:0]      char_xy_q, char_xy_d;
    logic [3:0]      row1_q, row1_d;
    logic [2:0]      bit1_q, bit1_d, bit2_q, bit2_d, bit3_q, bit3_d;
    logic            valid1_q, valid1_d, valid2_q, valid2_d, valid3_q, valid3_d;
    logic [10:0]     font_addr_q, font_addr_d;
    logic            text_on_q, text_on_d;

    logic [9:0]      dx, dy;
    logic            in_box;
    logic [6:0]      sel_code;

    assign dx     = pixel_x - 10'(TEXT_X0);
    assign dy     = pixel_y - 10'(TEXT_Y0);
    assign in_box = (pixel_x >= 10'(TEXT_X0)) && (dx < 10'(BOX_W)) &&
                    (pixel_y >= 10'(TEXT_Y0)) && (dy < 10'(BOX_H));

    always_comb begin
        state_d       = state_q;
        blink_cnt_d   = blink_cnt_q;
        blink_vis_d   = blink_vis_q;
        over_cnt_d    = over_cnt_q;
        disp_sel_d    = disp_sel_q;
        disp_vis_d    = disp_vis_q;
        case (state_q)
            ST_START: begin
                if (game_start) begin
                    state_d = ST_PLAY;
                end else if (frame_tick) begin
                    if (blink_cnt_q == BLINK_LAST) begin
                        blink_cnt_d = '0;
                        blink_vis_d = ~blink_vis_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + 1'b1;
                    end
                end
            end
            ST_PLAY: begin
                if (game_over) begin
                    state_d    = ST_OVER;
                    over_cnt_d = '0;
                end
            end
            ST_OVER: begin
                if (frame_tick) begin
                    over_cnt_d = over_cnt_q + 1'b1;
                    if (over_cnt_q == OVER_LAST) begin
                        state_d     = ST_START;
                        blink_cnt_d = '0;
                        blink_vis_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_START;
        endcase

        // Display view is sampled only at vblank so a frame is never torn mid-scan.
        if (frame_tick) begin
            case (state_d)
                ST_START: begin disp_sel_d = DISP_START; disp_vis_d = blink_vis_d; end
                ST_OVER:  begin disp_sel_d = DISP_OVER;  disp_vis_d = 1'b1;        end
                default:  begin disp_sel_d = DISP_NONE;  disp_vis_d = 1'b1;        end
            endcase
        end
        play_active_d = (state_d == ST_PLAY);

        char_xy_d   = {4'h0, dx[SCALE_LOG2+6:SCALE_LOG2+3]};
        row1_d      = dy[SCALE_LOG2+3:SCALE_LOG2];
        bit1_d      = dx[SCALE_LOG2+2:SCALE_LOG2];
        valid1_d    = in_box;

        // Message ROMs answer combinationally to char_xy during the second cycle.
        sel_code    = (disp_sel_q == DISP_OVER) ? over_code : start_code;
        font_addr_d = {sel_code, row1_q};
        bit2_d      = bit1_q;
        valid2_d    = valid1_q;

        bit3_d      = bit2_q;
        valid3_d    = valid2_q;

        text_on_d   = valid3_q && disp_vis_q && (disp_sel_q != DISP_NONE) &&
                      font_word[3'd7 - bit3_q];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_START;
            blink_cnt_q   <= '0;
            blink_vis_q   <= 1'b1;
            over_cnt_q    <= '0;
            disp_sel_q    <= DISP_START;
            disp_vis_q    <= 1'b1;
            play_active_q <= 1'b0;
            char_xy_q     <= '0;
            row1_q        <= '0;
            bit1_q        <= '0;
            valid1_q      <= 1'b0;
            font_addr_q   <= '0;
            bit2_q        <= '0;
            valid2_q      <= 1'b0;
            bit3_q        <= '0;
            valid3_q      <= 1'b0;
            text_on_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_vis_q   <= blink_vis_d;
            over_cnt_q    <= over_cnt_d;
            disp_sel_q    <= disp_sel_d;
            disp_vis_q    <= disp_vis_d;
            play_active_q <= play_active_d;
            char_xy_q     <= char_xy_d;
            row1_q        <= row1_d;
            bit1_q        <= bit1_d;
            valid1_q      <= valid1_d;
            font_addr_q   <= font_addr_d;
            bit2_q        <= bit2_d;
            valid2_q      <= valid2_d;
            bit3_q        <= bit3_d;
            valid3_q      <= valid3_d;
            text_on_q     <= text_on_d;
        end
    end

    assign char_xy     = char_xy_q;
    assign font_addr   = font_addr_q;
    assign text_on     = text_on_q;
    assign play_active = play_active_q;
endmodule

// File: tb/tb_pong_text_overlay_ctrl.sv
// Bench for pong_text_overlay_ctrl: directed game scenarios then random pixels/events,
// all scored against a frame-counting game model and arithmetic glyph lookup.
module tb_pong_text_overlay_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  pixel_x, pixel_y;
    logic        frame_tick, game_start, game_over;
    logic [7:0]  char_xy;
    logic [6:0]  start_code, over_code;
    logic [10:0] font_addr;
    logic [7:0]  font_word = 8'h00;
    logic        text_on, play_active;

    logic [6:0]  start_rom [16];
    logic [6:0]  over_rom  [16];
    logic [7:0]  font_mem  [2048];

    int checks = 0;
    int errors = 0;

    // model: 0 = start prompt, 1 = playing, 2 = game over
    int  m_mode, m_frames, m_disp;
    bit  m_dvis;
    bit  q_dc [$];
    bit  q_val[$];
    bit  has_fa;
    logic [10:0] fa_pend;

    pong_text_overlay_ctrl dut (
        .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .frame_tick(frame_tick), .game_start(game_start), .game_over(game_over),
        .char_xy(char_xy), .start_code(start_code), .over_code(over_code),
        .font_addr(font_addr), .font_word(font_word), .text_on(text_on),
        .play_active(play_active)
    );

    always #5 clk = ~clk;

    assign start_code = start_rom[char_xy[3:0]];
    assign over_code  = over_rom[char_xy[3:0]];
    always @(posedge clk) font_word <= font_mem[font_addr];

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_events(input bit ft, input bit gs, input bit go);
        if (m_mode == 0 && gs) begin
            m_mode = 1; m_frames = 0;
        end else if (m_mode == 1 && go) begin
            m_mode = 2; m_frames = 0;
        end else if (ft) begin
            m_frames++;
            if (m_mode == 2 && m_frames == 180) begin
                m_mode = 0; m_frames = 0;
            end
        end
        if (ft) begin
            m_disp = m_mode;
            m_dvis = (m_mode != 0) || ((m_frames / 30) % 2 == 0);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        m_mode = 0; m_frames = 0; m_disp = 0; m_dvis = 1'b1;
        q_dc.delete(); q_val.delete(); has_fa = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("rst_char_xy", 16'(char_xy), 16'h0);
        chk("rst_font_addr", 16'(font_addr), 16'h0);
        chk("rst_text_on", 16'(text_on), 16'h0);
        chk("rst_play_active", 16'(play_active), 16'h0);
        reset = 1'b0;
    endtask

    task automatic step(input int px, input int py, input bit ft, input bit gs, input bit go);
        int dx, dy, col, row, bp;
        bit inb, val;
        logic [6:0] code;
        pixel_x = 10'(px); pixel_y = 10'(py);
        frame_tick = ft; game_start = gs; game_over = go;
        model_events(ft, gs, go);
        dx   = (px - 192) & 1023;
        dy   = (py - 208) & 1023;
        inb  = (px >= 192) && (px < 448) && (py >= 208) && (py < 240);
        col  = (dx / 16) % 16;
        row  = (dy / 2) % 16;
        bp   = (dx / 2) % 8;
        code = (m_disp == 2) ? over_rom[col] : start_rom[col];
        val  = inb && (m_disp != 1) && m_dvis && font_mem[{code, 4'(row)}][7 - bp];
        // A vblank inside a pixel's pipeline window makes its gating ambiguous.
        if (ft) for (int i = 0; i < 2 && i < q_dc.size(); i++) q_dc[q_dc.size() - 1 - i] = 1'b1;
        q_dc.push_back(1'b0);
        q_val.push_back(val);
        @(posedge clk); @(negedge clk);
        frame_tick = 1'b0; game_start = 1'b0; game_over = 1'b0;
        chk("char_xy", 16'(char_xy), 16'(col));
        if (has_fa) chk("font_addr", 16'(font_addr), 16'(fa_pend));
        fa_pend = {code, 4'(row)};
        has_fa  = 1'b1;
        chk("play_active", 16'(play_active), 16'(m_mode == 1));
        if (q_dc.size() == 4) begin
            bit dc, ev;
            dc = q_dc.pop_front();
            ev = q_val.pop_front();
            if (!dc) chk("text_on", 16'(text_on), 16'(ev));
        end else begin
            chk("text_on_fill", 16'(text_on), 16'h0);
        end
    endtask

    task automatic sweep(input int y, input int x0, input int x1);
        for (int x = x0; x <= x1; x++) step(x, y, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(600, 400, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            start_rom[i] = 7'($urandom);
            over_rom[i]  = 7'($urandom);
        end
        for (int i = 0; i < 2048; i++) font_mem[i] = 8'($urandom);
        font_mem[{start_rom[0], 4'h0}] = 8'h80;
        pixel_x = 10'd0; pixel_y = 10'd0;
        frame_tick = 1'b0; game_start = 1'b0; game_over = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        do_reset();

        // first lit pixel at the box corner, four cycles after release
        for (int i = 0; i < 4; i++) step(192, 208, 1'b0, 1'b0, 1'b0);
        chk("corner_pixel_lit", 16'(text_on), 16'h1);

        sweep(208, 188, 452);
        sweep(207, 196, 204);
        sweep(239, 430, 450);
        sweep(240, 200, 204);

        // blink: hidden after 30 frames, shown again after 30 more
        ticks(30);
        sweep(210, 190, 300);
        ticks(30);
        sweep(210, 190, 300);

        // start mid-frame: text remains until vblank, then disappears
        step(250, 212, 1'b0, 1'b1, 1'b0);
        sweep(212, 251, 320);
        ticks(1);
        sweep(212, 190, 300);
        step(300, 215, 1'b0, 1'b1, 1'b0);

        // game over: steady over message, start ignored, back to start after 180 frames
        step(300, 215, 1'b0, 1'b0, 1'b1);
        sweep(215, 300, 310);
        ticks(1);
        sweep(220, 190, 450);
        for (int i = 0; i < 178; i++) step(600, 400, 1'b1, (i % 37) == 5, 1'b0);
        step(300, 230, 1'b0, 1'b1, 1'b0);
        sweep(230, 190, 260);
        ticks(1);
        sweep(230, 190, 260);

        // simultaneous start and over pulses
        step(200, 210, 1'b0, 1'b1, 1'b1);
        step(200, 210, 1'b0, 1'b1, 1'b1);
        ticks(2);
        sweep(225, 190, 250);
        ticks(180);
        sweep(225, 190, 250);

        // reset in the middle of a sweep
        sweep(216, 200, 230);
        do_reset();
        sweep(216, 200, 230);

        for (int i = 0; i < 2500; i++) begin
            int px, py;
            px = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 639) : $urandom_range(176, 463);
            py = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 479) : $urandom_range(196, 251);
            step(px, py, $urandom_range(0, 5) == 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 39) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
